// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, widths and the address-check helper for the data-memory responder
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int WORD_W = 32;
    localparam int STRB_W = 4;
    function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || (32'(addr[31:2]) >= depth);
    endfunction
endpackage

// File: rtl/dmem_if.sv
// dmem_if: load/store request and response channels between CPU (master) and memory (slave)
// req_*: valid/ready request with write flag, byte address, store data and byte strobes
// resp_*: valid/ready response with load data and error flag
interface dmem_if;
    import dmem_pkg::*;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              resp_valid;
    logic              resp_ready;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_lat_counter.sv
// dmem_lat_counter: loadable down-counter with zero flag used to time the response latency
// clk/rst: clock and async active-low reset; i_load/i_val: load value; i_en: decrement; o_zero: count is 0
module dmem_lat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_en,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            r_cnt <= '0;
        else
            r_cnt <= i_load ? i_val : (i_en && r_cnt != '0) ? r_cnt - W'(1) : r_cnt;
    assign o_zero = r_cnt == '0;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory answering one load/store at a time after LATENCY cycles
// clk/rst: clock and async active-low reset; bus: dmem_if slave (request in, response out)
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    dmem_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);
    state_t            r_state;
    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;
    logic              r_err;
    logic              w_accept;
    logic              w_err;
    logic              w_zero;
    logic [AW-1:0]     w_idx;
    assign w_accept       = bus.req_valid && r_state == IDLE;
    assign w_err          = addr_err(bus.req_addr, DEPTH);
    assign w_idx          = bus.req_addr[AW+1:2];
    assign bus.req_ready  = r_state == IDLE;
    assign bus.resp_valid = r_state == RESP;
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
    // WAIT lasts LATENCY-1 cycles, so the counter is loaded with LATENCY-2 and WAIT exits on zero
    dmem_lat_counter #(.W(CW)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept),
        .i_val  (CW'(LATENCY > 1 ? LATENCY - 2 : 0)),
        .i_en   (r_state == WAIT),
        .o_zero (w_zero)
    );
    // Memory is touched only at the acceptance edge, so each request reads or writes exactly once
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_state <= IDLE;
            r_rdata <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            case (r_state)
                IDLE:
                    if (bus.req_valid) begin
                        r_err   <= w_err;
                        r_rdata <= (w_err || bus.req_write) ? '0 : r_mem[w_idx];
                        if (!w_err && bus.req_write)
                            for (int i = 0; i < STRB_W; i++)
                                if (bus.req_wstrb[i])
                                    r_mem[w_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                        r_state <= LATENCY == 1 ? RESP : WAIT;
                    end
                WAIT:    r_state <= w_zero ? RESP : WAIT;
                RESP:    r_state <= bus.resp_ready ? IDLE : RESP;
                default: r_state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized self-checking bench for two responders (LATENCY=2 and LATENCY=1)
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        t_valid = 1'b0, t_write = 1'b0, t_ready = 1'b0;
    logic [31:0] t_addr = '0, t_wdata = '0;
    logic [3:0]  t_strb = '0;

    dmem_if b2 ();
    dmem_if b1 ();
    assign b2.req_valid  = t_valid & ~sel;
    assign b1.req_valid  = t_valid & sel;
    assign b2.resp_ready = t_ready & ~sel;
    assign b1.resp_ready = t_ready & sel;
    assign b2.req_write  = t_write;
    assign b1.req_write  = t_write;
    assign b2.req_addr   = t_addr;
    assign b1.req_addr   = t_addr;
    assign b2.req_wdata  = t_wdata;
    assign b1.req_wdata  = t_wdata;
    assign b2.req_wstrb  = t_strb;
    assign b1.req_wstrb  = t_strb;

    dmem_responder #(.DEPTH(256), .LATENCY(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
    dmem_responder #(.DEPTH(256), .LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(b1));

    logic        o_rv, o_rr, o_er;
    logic [31:0] o_rd;
    assign o_rv = sel ? b1.resp_valid : b2.resp_valid;
    assign o_rr = sel ? b1.req_ready  : b2.req_ready;
    assign o_er = sel ? b1.resp_err   : b2.resp_err;
    assign o_rd = sel ? b1.resp_rdata : b2.resp_rdata;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] mdl [2][256];

    function automatic void mdl_clear();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++)
                mdl[k][i] = '0;
    endfunction

    // Reference: word memory of 256 entries; any misaligned or >= 1 KiB byte address is an error
    function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] s, output logic [31:0] rd, output logic e);
        e  = (a % 4 != 0) || (a >= 32'd1024);
        rd = '0;
        if (!e && w)
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[sel][a / 4][8*b +: 8] = d[8*b +: 8];
        if (!e && !w) rd = mdl[sel][a / 4];
    endfunction

    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int bp, output logic rr0, output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        t_valid = 1'b1; t_write = w; t_addr = a; t_wdata = d; t_strb = s;
        #1 rr0 = o_rr;
        @(posedge clk);
        #1 t_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (o_rv) break;
        end
        rd = o_rd; er = o_er;
        repeat (bp) @(negedge clk);
        t_ready = 1'b1;
        @(posedge clk);
        #1 t_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic rr0, er; logic [31:0] rd; int lat;
        rst = 1'b0; sel = 1'b0;
        t_valid = 1'b1; t_write = 1'($urandom_range(0, 1)); t_addr = $urandom & 32'h3FC;
        t_wdata = $urandom; t_strb = 4'hF;
        repeat (3) @(negedge clk);
        n_cmp++; if (o_rr !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b want 1", o_rr); end
        n_cmp++; if (o_rv !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b want 0", o_rv); end
        n_cmp++; if (o_rd !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", o_rd); end
        n_cmp++; if (o_er !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", o_er); end
        t_valid = 1'b0;
        rst = 1'b1;
        mdl_clear();
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0, rr0, rd, er, lat);
        n_cmp++; if (rd !== 32'h0 || er !== 1'b0) begin n_err++; $display("FAIL rst_load10: got %h/%b want 00000000/0", rd, er); end
    endtask

    task automatic test_store_load();
        logic rr0, er, ee; logic [31:0] rd, er_d; int lat;
        sel = 1'b0;
        model(1'b1, 32'h20, 32'hDEADBEEF, 4'hF, er_d, ee);
        xact(1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 0, rr0, rd, er, lat);
        n_cmp++; if (rr0 !== 1'b1) begin n_err++; $display("FAIL st_req_ready: got %b want 1", rr0); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL st_latency: got %0d want 2", lat); end
        n_cmp++; if (rd !== 32'h0 || er !== 1'b0) begin n_err++; $display("FAIL st_resp: got %h/%b want 00000000/0", rd, er); end
        model(1'b0, 32'h20, 32'h0, 4'h0, er_d, ee);
        xact(1'b0, 32'h20, 32'h0, 4'h0, 0, rr0, rd, er, lat);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL ld_latency: got %0d want 2", lat); end
        n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_err++; $display("FAIL ld_data: got %h/%b want deadbeef/0", rd, er); end
    endtask

    task automatic test_strobes();
        logic rr0, er, ee; logic [31:0] rd, exp_d; int lat;
        sel = 1'b0;
        model(1'b1, 32'h40, 32'h11223344, 4'hF, exp_d, ee);
        xact(1'b1, 32'h40, 32'h11223344, 4'hF, 0, rr0, rd, er, lat);
        model(1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, exp_d, ee);
        xact(1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, 1, rr0, rd, er, lat);
        model(1'b1, 32'h44, 32'h55667788, 4'h0, exp_d, ee);
        xact(1'b1, 32'h44, 32'h55667788, 4'h0, 0, rr0, rd, er, lat);
        n_cmp++; if (lat !== 2 || er !== 1'b0) begin n_err++; $display("FAIL strb0_resp: got lat %0d err %b want 2/0", lat, er); end
        model(1'b0, 32'h40, 32'h0, 4'h0, exp_d, ee);
        xact(1'b0, 32'h40, 32'h0, 4'h0, 0, rr0, rd, er, lat);
        n_cmp++; if (rd !== 32'h11BB33DD) begin n_err++; $display("FAIL strb_merge: got %h want 11bb33dd", rd); end
        xact(1'b0, 32'h44, 32'h0, 4'h0, 0, rr0, rd, er, lat);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL strb0_noop: got %h want 00000000", rd); end
    endtask

    task automatic test_backpressure();
        logic rr0, er, ee, er0; logic [31:0] rd, rd0, exp_d; int lat;
        sel = 1'b0;
        model(1'b0, 32'h20, 32'h0, 4'h0, exp_d, ee);
        @(negedge clk);
        t_valid = 1'b1; t_write = 1'b0; t_addr = 32'h20; t_strb = 4'($urandom);
        @(posedge clk);
        #1 t_valid = 1'b0;
        repeat (2) @(negedge clk);
        rd0 = o_rd; er0 = o_er;
        n_cmp++; if (o_rv !== 1'b1 || rd0 !== exp_d || er0 !== 1'b0) begin n_err++; $display("FAIL bp_first: got %b/%h/%b want 1/%h/0", o_rv, rd0, er0, exp_d); end
        // a store presented while the response is pending must be ignored
        t_valid = 1'b1; t_write = 1'b1; t_addr = 32'h20; t_wdata = 32'hFFFFFFFF; t_strb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (o_rv !== 1'b1 || o_rd !== rd0 || o_er !== er0 || o_rr !== 1'b0) begin n_err++;
                $display("FAIL bp_hold%0d: got v%b d%h e%b r%b want v1 d%h e%b r0", i, o_rv, o_rd, o_er, o_rr, rd0, er0); end
        end
        t_ready = 1'b1;
        #1;
        n_cmp++; if (o_rr !== 1'b0) begin n_err++; $display("FAIL bp_ready_early: got %b want 0", o_rr); end
        @(posedge clk);
        #1 t_ready = 1'b0; t_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (o_rr !== 1'b1 || o_rv !== 1'b0 || o_rd !== rd0) begin n_err++; $display("FAIL bp_after: got r%b v%b d%h want r1 v0 d%h", o_rr, o_rv, o_rd, rd0); end
        model(1'b0, 32'h20, 32'h0, 4'h0, exp_d, ee);
        xact(1'b0, 32'h20, 32'h0, 4'h0, 0, rr0, rd, er, lat);
        n_cmp++; if (rd !== exp_d) begin n_err++; $display("FAIL bp_ignored_store: got %h want %h", rd, exp_d); end
    endtask

    task automatic test_errors();
        logic rr0, er, ee; logic [31:0] rd, exp_d; int lat;
        sel = 1'b0;
        xact(1'b0, 32'h22, 32'h0, 4'h0, 0, rr0, rd, er, lat);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin n_err++; $display("FAIL err_misalign: got %b/%h/%0d want 1/00000000/2", er, rd, lat); end
        xact(1'b1, 32'h400, 32'h12345678, 4'hF, 0, rr0, rd, er, lat);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL err_range: got %b/%h want 1/00000000", er, rd); end
        xact(1'b0, 32'h0, 32'h0, 4'h0, 0, rr0, rd, er, lat);
        n_cmp++; if (er !== 1'b0 || rd !== 32'h0) begin n_err++; $display("FAIL err_nowrite: got %b/%h want 0/00000000", er, rd); end
        model(1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, exp_d, ee);
        xact(1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 0, rr0, rd, er, lat);
        n_cmp++; if (er !== 1'b0) begin n_err++; $display("FAIL err_lastword: got %b want 0", er); end
        model(1'b0, 32'h3FC, 32'h0, 4'h0, exp_d, ee);
        xact(1'b0, 32'h3FC, 32'h0, 4'h0, 0, rr0, rd, er, lat);
        n_cmp++; if (rd !== exp_d) begin n_err++; $display("FAIL err_lastword_ld: got %h want %h", rd, exp_d); end
    endtask

    task automatic test_reset_midop();
        logic rr0, er, ee, seen; logic [31:0] rd, exp_d; int lat;
        sel = 1'b0;
        @(negedge clk);
        t_valid = 1'b1; t_write = 1'b1; t_addr = 32'h30; t_wdata = 32'h0BADF00D; t_strb = 4'hF;
        @(posedge clk);
        #1 t_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (o_rr !== 1'b1 || o_rv !== 1'b0) begin n_err++; $display("FAIL mid_async: got r%b v%b want r1 v0", o_rr, o_rv); end
        @(negedge clk);
        rst = 1'b1;
        mdl_clear();
        seen = 1'b0;
        repeat (4) begin @(negedge clk); seen |= o_rv; end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_no_resp: got %b want 0", seen); end
        model(1'b0, 32'h30, 32'h0, 4'h0, exp_d, ee);
        xact(1'b0, 32'h30, 32'h0, 4'h0, 0, rr0, rd, er, lat);
        n_cmp++; if (rr0 !== 1'b1 || lat !== 2 || rd !== exp_d) begin n_err++; $display("FAIL mid_next: got r%b lat%0d d%h want r1 lat2 d%h", rr0, lat, rd, exp_d); end
    endtask

    task automatic test_lat1();
        logic rr0, er, ee; logic [31:0] rd, exp_d; int lat;
        sel = 1'b1;
        model(1'b1, 32'h80, 32'h13579BDF, 4'hF, exp_d, ee);
        xact(1'b1, 32'h80, 32'h13579BDF, 4'hF, 0, rr0, rd, er, lat);
        n_cmp++; if (lat !== 1 || er !== 1'b0 || rd !== 32'h0) begin n_err++; $display("FAIL l1_store: got lat%0d %b/%h want lat1 0/00000000", lat, er, rd); end
        model(1'b0, 32'h80, 32'h0, 4'h0, exp_d, ee);
        xact(1'b0, 32'h80, 32'h0, 4'h0, 0, rr0, rd, er, lat);
        n_cmp++; if (lat !== 1 || rd !== 32'h13579BDF) begin n_err++; $display("FAIL l1_load: got lat%0d %h want lat1 13579bdf", lat, rd); end
        sel = 1'b0;
    endtask

    task automatic test_random();
        logic rr0, er, ee, w; logic [31:0] rd, exp_d, a, d; logic [3:0] s; int lat, r;
        for (int i = 0; i < 60; i++) begin
            sel = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            a = r == 0 ? (($urandom & 32'h3FC) | 32'($urandom_range(1, 3))) :
                r == 1 ? (32'h400 + ($urandom & 32'hFFFC)) : 32'($urandom_range(0, 15) * 4);
            w = 1'($urandom_range(0, 1)); d = $urandom; s = 4'($urandom);
            model(w, a, d, s, exp_d, ee);
            xact(w, a, d, s, $urandom_range(0, 3), rr0, rd, er, lat);
            n_cmp++; if (lat !== (sel ? 1 : 2)) begin n_err++; $display("FAIL rnd%0d_lat: got %0d want %0d", i, lat, sel ? 1 : 2); end
            n_cmp++; if (er !== ee || rd !== exp_d) begin n_err++; $display("FAIL rnd%0d_resp a=%h w=%b: got %b/%h want %b/%h", i, a, w, er, rd, ee, exp_d); end
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_strobes();
        test_backpressure();
        test_errors();
        test_reset_midop();
        test_lat1();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
